pengumpan_matrix: RTL and testbench
===================================

PENGUMPAN_MATRIX -- requirements
Module: pengumpan_matrix

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of every data word, in and out.
REQ-002 Parameter DIM, default 3, SHALL be the matrix order; only DIM=3 is supported, and the block SHALL fail elaboration for any other value.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL mark in_data as valid.
REQ-006 in_data  input  DATA_W  SHALL be the load word.
REQ-007 in_ready  output  1  SHALL be high when a word can be accepted.
REQ-008 col_a, col_b, col_c  output  DATA_W each  SHALL carry row r of matrix M (elements M[r][0..2]).
REQ-009 row_a, row_b, row_c  output  DATA_W each  SHALL carry column vector N (N[0..2]).
REQ-010 out_valid  output  1  SHALL mark the issued row as valid.
REQ-011 out_ready  input  1  SHALL be the downstream acceptance signal; tie it high for the multiplier stage.
REQ-012 out_row  output  2  SHALL give the row index r of the issued row (0..2).
REQ-013 out_last  output  1  SHALL be high together with out_valid when r=2.

Function
REQ-014 The block SHALL buffer 12 words: M row-major (words 0..8), then N[0..2] (words 9..11). This is the order of memory_in.list.
REQ-015 A word SHALL be accepted on any clock edge where in_valid and in_ready are both high.
REQ-016 The FSM SHALL have exactly two states: LOAD and ISSUE.
REQ-017 LOAD behaviour:
- in_ready = 1 and out_valid = 0.
- The load counter SHALL increment 0..11 on each accepted word.
- The edge that accepts word 11 SHALL move the FSM to ISSUE and clear the load counter.
REQ-018 ISSUE behaviour:
- in_ready = 0 and out_valid = 1.
- Row counter r starts at 0.
- Outputs SHALL be driven from registers: col_* = M[r][*], row_* = N[*].
REQ-019 While in ISSUE, r SHALL advance on each edge where out_ready is high.
REQ-020 The edge that completes r=2 with out_ready high SHALL return the FSM to LOAD with r cleared.
REQ-021 Latency: when word 11 is accepted at edge t, the first row SHALL be valid from edge t through edge t+1.
- With out_ready held high, the three rows SHALL issue in 3 consecutive cycles.
- in_ready SHALL return high in the cycle after the row-2 handshake.
REQ-022 Backpressure: while out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-023 in_data words arriving during ISSUE SHALL NOT be accepted, and stored words SHALL NOT change.
REQ-024 Storage SHALL be fully overwritten on every load; there is no partial reuse of N.
REQ-025 The block SHALL pass data through unchanged; it performs no arithmetic and no width change.
REQ-026 If in_valid drops mid-load, the load counter SHALL hold and load SHALL resume with the next valid word.
REQ-027 Once in ISSUE, the FSM SHALL remain there until all three rows are accepted.

Reset
REQ-028 While rst is high, the block SHALL:
- put the FSM in LOAD;
- clear both counters and all storage;
- drive in_ready = 0, out_valid = 0, out_last = 0, out_row = 0 and all col_*/row_* = 0.
REQ-029 After rst deasserts, in_ready SHALL be 1 in the first cycle.
REQ-030 A reset asserted mid-load or mid-issue SHALL discard all buffered data immediately and asynchronously.

Structure
REQ-031 DATA_W, DIM and the state encodings (LOAD=0, ISSUE=1) SHALL live in a shared package, matrix_pkg, and be reused by the multiplier and the collector.
REQ-032 The block SHALL be one flat module; the 12-entry register file is the only natural sub-module, named matrix_regfile (write port plus three parallel read ports).

Verification
REQ-033 Basic load/issue:
- Stimulus: load words 1..9 for M and 1,2,3 for N, out_ready=1.
- Response: rows (1,2,3), (4,5,6), (7,8,9) on consecutive cycles with N=(1,2,3).
- The multiplier output then SHALL read 14, 32, 50.
REQ-034 Backpressure:
- Stimulus: hold out_ready=0 for 4 cycles at r=1.
- Response: col_*=(4,5,6), out_row=1 and out_valid=1 held stable for all 4 cycles; r=2 follows one cycle after out_ready rises.
REQ-035 Gapped load:
- Stimulus: in_valid toggles every other cycle.
- Response: 12 words accepted in 23 cycles; first issue one edge after the 12th accept.
REQ-036 Input during issue:
- Stimulus: drive in_valid=1 with 0xFFFF throughout ISSUE.
- Response: in_ready=0 and no stored word changes.
- The next load SHALL start at word 0.
REQ-037 Mid-issue reset:
- Stimulus: pulse rst while r=1.
- Response: out_valid=0 immediately; all outputs 0 while rst is high; in_ready=1 after release.
REQ-038 Back-to-back batches:
- Stimulus: reload immediately with M = identity and N=(7,8,9).
- Response: rows (1,0,0), (0,1,0), (0,0,1) issued; out_last high only on row 2.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix feeder, multiplier and collector: word width,
// matrix order, buffer depth, FSM encoding and the row-to-address helper.
package matrix_pkg;

  localparam int DATA_W = 16;
  localparam int DIM    = 3;
  localparam int WORDS  = DIM * DIM + DIM;
  localparam int ADDR_W = $clog2(WORDS);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
  localparam logic [1:0]        LAST_ROW  = 2'(DIM - 1);

  typedef enum logic {
    LOAD  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // M is stored row-major, so row r starts at address 3*r.
  function automatic logic [ADDR_W-1:0] row_base(input logic [1:0] r);
    return ADDR_W'(r) * ADDR_W'(DIM);
  endfunction

endpackage

// File: rtl/matrix_regfile.sv
// 12-word storage for one batch: M row-major in 0..8, N in 9..11. One write port,
// three parallel read ports for a row of M, and fixed taps for the N vector.
module matrix_regfile #(
  parameter int DATA_W = matrix_pkg::DATA_W,
  parameter int DEPTH  = matrix_pkg::WORDS,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  input  logic [ADDR_W-1:0] raddr_c_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [DATA_W-1:0] rdata_c_o,
  output logic [DATA_W-1:0] vec_a_o,
  output logic [DATA_W-1:0] vec_b_o,
  output logic [DATA_W-1:0] vec_c_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
  assign rdata_c_o = mem_q[raddr_c_i];

  // The vector always occupies the last three entries.
  assign vec_a_o = mem_q[DEPTH-3];
  assign vec_b_o = mem_q[DEPTH-2];
  assign vec_c_o = mem_q[DEPTH-1];

endmodule

// File: rtl/pengumpan_matrix.sv
// Matrix feeder: collects a 3x3 matrix M and vector N word by word, then issues
// M one row at a time alongside N to the downstream multiplier.
module pengumpan_matrix #(
  parameter int DATA_W = matrix_pkg::DATA_W,
  parameter int DIM    = matrix_pkg::DIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] col_a,
  output logic [DATA_W-1:0] col_b,
  output logic [DATA_W-1:0] col_c,
  output logic [DATA_W-1:0] row_a,
  output logic [DATA_W-1:0] row_b,
  output logic [DATA_W-1:0] row_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_row,
  output logic              out_last,
  output logic              dbg_state_o
);

  import matrix_pkg::*;

  if (DIM != 3) begin : g_dim_check
    $error("pengumpan_matrix supports only DIM=3");
  end

  // Handshakes: a word moves on a rising edge where valid and ready are both high;
  // valid never depends on ready, and a producer holds its data while valid && !ready.
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
  logic [1:0]        row_q, row_d;
  logic              accept;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] rd_a, rd_b, rd_c, vec_a, vec_b, vec_c;

  assign in_ready  = (state_q == LOAD) && !rst;
  assign out_valid = (state_q == ISSUE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      row_q      <= row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    row_d      = row_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (load_cnt_q == LAST_WORD) begin
            load_cnt_d = '0;
            row_d      = '0;
            state_d    = ISSUE;
          end else begin
            load_cnt_d = load_cnt_q + ADDR_W'(1);
          end
        end
      end
      ISSUE: begin
        if (out_ready) begin
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = LOAD;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign base = row_base(row_q);

  matrix_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (accept),
    .waddr_i   (load_cnt_q),
    .wdata_i   (in_data),
    .raddr_a_i (base),
    .raddr_b_i (base + ADDR_W'(1)),
    .raddr_c_i (base + ADDR_W'(2)),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b),
    .rdata_c_o (rd_c),
    .vec_a_o   (vec_a),
    .vec_b_o   (vec_b),
    .vec_c_o   (vec_c)
  );

  // Data outputs read as zero whenever no row is being offered.
  assign col_a = out_valid ? rd_a  : '0;
  assign col_b = out_valid ? rd_b  : '0;
  assign col_c = out_valid ? rd_c  : '0;
  assign row_a = out_valid ? vec_a : '0;
  assign row_b = out_valid ? vec_b : '0;
  assign row_c = out_valid ? vec_c : '0;

  assign out_row     = row_q;
  assign out_last    = out_valid && (row_q == LAST_ROW);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pengumpan_matrix.sv
// Self-checking bench for pengumpan_matrix: expected rows and dot products are
// queued when a batch is loaded and compared as each row is handshaken out.
module tb_pengumpan_matrix;

  localparam int W  = 16;
  localparam int EW = 2 + 1 + 6 * W;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, dbg_state;
  logic [W-1:0] in_data, col_a, col_b, col_c, row_a, row_b, row_c;
  logic [1:0]   out_row;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_first, acc_last;

  logic [EW-1:0] exp_q[$];
  logic [63:0]   exp_dot_q[$];
  logic [W-1:0]  w [12];

  pengumpan_matrix #(.DATA_W(W), .DIM(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .col_a(col_a), .col_b(col_b), .col_c(col_c), .row_a(row_a), .row_b(row_b), .row_c(row_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  128'(in_ready),  128'(0));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_out_last"},  128'(out_last),  128'(0));
    check({tag, "_out_row"},   128'(out_row),   128'(0));
    check({tag, "_data"}, 128'({col_a, col_b, col_c, row_a, row_b, row_c}), 128'(0));
  endtask

  // ---------------- scoreboard ----------------
  task automatic push_batch(input logic [W-1:0] b [12]);
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back({2'(r), (r == 2) ? 1'b1 : 1'b0, b[3*r], b[3*r+1], b[3*r+2], b[9], b[10], b[11]});
      exp_dot_q.push_back(64'(b[3*r]) * 64'(b[9]) + 64'(b[3*r+1]) * 64'(b[10]) +
                          64'(b[3*r+2]) * 64'(b[11]));
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    logic [63:0]   d;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_row", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        d = exp_dot_q.pop_front();
        check("row", 128'({out_row, out_last, col_a, col_b, col_c, row_a, row_b, row_c}), 128'(e));
        check("dot", 128'(64'(col_a) * 64'(row_a) + 64'(col_b) * 64'(row_b) + 64'(col_c) * 64'(row_c)),
              128'(d));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic load_batch(input logic [W-1:0] b [12], input bit gapped);
    int n;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = b[i];
      n = 0;
      while (!in_ready && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 100) begin
        check("load_ready_timeout", 128'(0), 128'(1));
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      if (i == 0) acc_first = cyc;
      if (i == 11) acc_last = cyc;
      #1;
      if (gapped && i < 11) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 12; i++) w[i] = W'($urandom_range(0, 16'hFFFE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int it;
    bit done;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 128'(in_ready), 128'(1));
    check("state_load", 128'(dbg_state), 128'(0));

    // basic load and back-to-back issue of three rows
    for (int i = 0; i < 9; i++) w[i] = W'(i + 1);
    w[9] = 16'd1; w[10] = 16'd2; w[11] = 16'd3;
    push_batch(w);
    load_batch(w, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("basic_valid", 128'(out_valid), 128'(1));
      check("basic_row", 128'(out_row), 128'(k));
      check("basic_ready_low", 128'(in_ready), 128'(0));
    end
    check("state_issue", 128'(dbg_state), 128'(1));
    @(negedge clk);
    check("basic_ready_back", 128'(in_ready), 128'(1));
    check("basic_valid_low", 128'(out_valid), 128'(0));
    check("basic_drained", 128'(exp_q.size()), 128'(0));

    // backpressure at r=1
    push_batch(w);
    load_batch(w, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_cols", 128'({col_a, col_b, col_c}), 128'({16'd4, 16'd5, 16'd6}));
      check("bp_row", 128'(out_row), 128'(1));
      check("bp_valid", 128'(out_valid), 128'(1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_row", 128'(out_row), 128'(1));
    @(negedge clk);
    check("bp_next_row", 128'(out_row), 128'(2));
    wait_drain("bp");

    // input held high with 0xFFFF throughout issue, random backpressure
    fill_random();
    push_batch(w);
    load_batch(w, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    it = 0;
    done = 1'b0;
    while (!done && it < 40) begin
      @(negedge clk);
      if (!out_valid) begin
        done = 1'b1;
      end else begin
        check("issue_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        out_ready = (it >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        it++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (!done) check("issue_timeout", 128'(0), 128'(1));
    wait_drain("issue_in");

    // gapped load: must start at word 0 after the ignored 0xFFFF traffic
    fill_random();
    push_batch(w);
    load_batch(w, 1'b1);
    check("gap_cycles", 128'(acc_last - acc_first + 1), 128'(23));
    @(negedge clk);
    check("gap_first_issue_valid", 128'(out_valid), 128'(1));
    check("gap_first_issue_row", 128'(out_row), 128'(0));
    wait_drain("gap");

    // reset pulsed while r=1
    fill_random();
    w[0] = 16'h1234;
    push_batch(w);
    load_batch(w, 1'b0);
    @(posedge clk); #1;
    check("mid_rst_row1", 128'(out_row), 128'(1));
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    exp_dot_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("mid_rst_hold");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    check("mid_rst_idle", 128'(out_valid), 128'(0));

    // back-to-back: a batch followed at once by identity M with N=(7,8,9)
    for (int i = 0; i < 9; i++) w[i] = W'(i + 1);
    w[9] = 16'd1; w[10] = 16'd2; w[11] = 16'd3;
    push_batch(w);
    load_batch(w, 1'b0);
    for (int i = 0; i < 12; i++) w[i] = '0;
    w[0] = 16'd1; w[4] = 16'd1; w[8] = 16'd1;
    w[9] = 16'd7; w[10] = 16'd8; w[11] = 16'd9;
    push_batch(w);
    load_batch(w, 1'b0);
    wait_drain("b2b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    check("watchdog", 128'(0), 128'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
